// File: rtl/inst_sequencer.sv
// Two-phase instruction sequencer: fetches a 30-bit word, then executes it against
// the acc/dat registers, an external ALU and a test flag, with an optional timed sleep.
module inst_sequencer #(
  parameter int unsigned LAST_PC = 13
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  prog_addr,
  input  logic [29:0] prog_data,
  input  logic [10:0] in_p0,
  output logic [3:0]  alu_inst,
  output logic [10:0] alu_arg1,
  output logic [10:0] alu_arg2,
  output logic [10:0] alu_acc,
  input  logic [10:0] alu_out,
  output logic [10:0] acc_q,
  output logic [10:0] dat_q,
  output logic        flag_q,
  output logic        flag_vld
);

  // state | meaning
  // FETCH | present PC to program memory
  // EXEC  | decode prog_data, write back registers, update PC
  // SLEEP | idle until the sleep counter reaches zero
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    SLEEP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  pc, pc_nxt, pc_inc;
  logic [10:0] acc, acc_nxt, dat, dat_nxt;
  logic [10:0] slp_cnt, slp_cnt_nxt;
  logic        flag, flag_nxt, vld, vld_nxt;
  logic        run;
  logic [3:0]  alu_op;

  logic [1:0]  cond;
  logic [3:0]  op;
  logic        a1_reg, a2_reg;
  logic [10:0] a1, a2, arg1, arg2;

  assign cond   = prog_data[29:28];
  assign op     = prog_data[27:24];
  assign a1_reg = prog_data[23];
  assign a1     = prog_data[22:12];
  assign a2_reg = prog_data[11];
  assign a2     = prog_data[10:0];

  function automatic logic [10:0] operand(input logic        is_reg,
                                          input logic [10:0] field,
                                          input logic [10:0] acc_v,
                                          input logic [10:0] dat_v,
                                          input logic [10:0] port_v);
    logic [10:0] val;
    val = field;
    if (is_reg) begin
      case (field[1:0])
        2'd0:    val = acc_v;
        2'd1:    val = dat_v;
        2'd2:    val = port_v;
        default: val = 11'd0;
      endcase
    end
    return val;
  endfunction

  assign arg1   = operand(a1_reg, a1, acc, dat, in_p0);
  assign arg2   = operand(a2_reg, a2, acc, dat, in_p0);
  assign pc_inc = (pc == 4'(LAST_PC)) ? 4'd0 : pc + 4'd1;
  assign alu_op = (op >= 4'd5 && op <= 4'd8) ? op : 4'd0;

  always_comb begin
    case (cond)
      2'd0:    run = 1'b1;
      2'd1:    run = vld & flag;
      2'd2:    run = vld & ~flag;
      default: run = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    acc_nxt     = acc;
    dat_nxt     = dat;
    flag_nxt    = flag;
    vld_nxt     = vld;
    slp_cnt_nxt = slp_cnt;
    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        if (run) begin
          case (op)
            4'd1: acc_nxt = arg1;
            4'd2: dat_nxt = arg1;
            // Out-of-range or negative targets restart the program.
            4'd3: pc_nxt = (arg1[10] || arg1[9:0] > 10'(LAST_PC)) ? 4'd0 : arg1[3:0];
            4'd4: begin
              if (!arg1[10] && arg1 != 11'd0) begin
                slp_cnt_nxt = arg1 - 11'd1;
                state_nxt   = SLEEP;
              end
            end
            4'd5, 4'd6, 4'd7, 4'd8: acc_nxt = alu_out;
            4'd9: begin
              acc_nxt = dat;
              dat_nxt = acc;
            end
            4'd12: begin
              flag_nxt = (arg1 == arg2);
              vld_nxt  = 1'b1;
            end
            4'd13: begin
              flag_nxt = ($signed(arg1) > $signed(arg2));
              vld_nxt  = 1'b1;
            end
            4'd14: begin
              flag_nxt = ($signed(arg1) < $signed(arg2));
              vld_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      SLEEP: begin
        if (slp_cnt == 11'd0) state_nxt = FETCH;
        else                  slp_cnt_nxt = slp_cnt - 11'd1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= 4'd0;
      acc     <= 11'd0;
      dat     <= 11'd0;
      flag    <= 1'b0;
      vld     <= 1'b0;
      slp_cnt <= 11'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      acc     <= acc_nxt;
      dat     <= dat_nxt;
      flag    <= flag_nxt;
      vld     <= vld_nxt;
      slp_cnt <= slp_cnt_nxt;
    end
  end

  // Gate with rst so outputs read as reset values even before the first reset edge.
  assign prog_addr = rst ? 4'd0 : pc;
  assign alu_inst  = (!rst && state == EXEC) ? alu_op : 4'd0;
  assign alu_arg1  = (!rst && state == EXEC) ? arg1 : 11'd0;
  assign alu_arg2  = (!rst && state == EXEC) ? arg2 : 11'd0;
  assign alu_acc   = acc;
  assign acc_q     = acc;
  assign dat_q     = dat;
  assign flag_q    = flag;
  assign flag_vld  = vld;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: registered program memory and a small ALU model
// (5 add, 6 sub, 7 and, 8 or) drive the DUT; expected values are hand-computed.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  prog_addr;
  logic [29:0] prog_data;
  logic [10:0] in_p0;
  logic [3:0]  alu_inst;
  logic [10:0] alu_arg1, alu_arg2, alu_acc, alu_out;
  logic [10:0] acc_q, dat_q;
  logic        flag_q, flag_vld;

  logic [29:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;

  inst_sequencer #(.LAST_PC(13)) dut (
    .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_p0(in_p0), .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_acc(alu_acc), .alu_out(alu_out), .acc_q(acc_q), .dat_q(dat_q),
    .flag_q(flag_q), .flag_vld(flag_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= mem[prog_addr];

  always_comb begin
    case (alu_inst)
      4'd5:    alu_out = alu_acc + alu_arg1;
      4'd6:    alu_out = alu_acc - alu_arg1;
      4'd7:    alu_out = alu_acc & alu_arg1;
      4'd8:    alu_out = alu_acc | alu_arg1;
      default: alu_out = 11'd0;
    endcase
  end

  function automatic logic [29:0] ins(input logic [1:0] c, input logic [3:0] op,
                                      input logic r1, input logic [10:0] a1,
                                      input logic r2, input logic [10:0] a2);
    return {c, op, r1, a1, r2, a2};
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 30'd0;
  endtask

  // Leaves the DUT one step past its reset edge, in FETCH of word 0.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    in_p0 = 11'd0;
    clear_mem();
    prog_data = 30'd0;
    tick(2);

    // reset values, with a nonzero input port
    in_p0 = 11'd77;
    tick(1);
    check("rst_prog_addr", 32'(prog_addr), 0);
    check("rst_alu_inst",  32'(alu_inst), 0);
    check("rst_arg1",      32'(alu_arg1), 0);
    check("rst_arg2",      32'(alu_arg2), 0);
    check("rst_acc",       32'(acc_q), 0);
    check("rst_flag_vld",  32'(flag_vld), 0);

    // MOV 5; ADD 7; MOVD acc
    clear_mem();
    mem[0] = ins(2'd0, 4'd1, 1'b0, 11'd5, 1'b0, 11'd0);
    mem[1] = ins(2'd0, 4'd5, 1'b0, 11'd7, 1'b0, 11'd0);
    mem[2] = ins(2'd0, 4'd2, 1'b1, 11'd0, 1'b0, 11'd0);
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("add_alu_inst_c%0d", c), 32'(alu_inst), (c == 4) ? 5 : 0);
      tick(1);
    end
    check("add_acc", 32'(acc_q), 12);
    check("add_dat", 32'(dat_q), 12);

    // TEQ 3,3; +MOV 9; -MOV 1
    clear_mem();
    mem[0] = ins(2'd0, 4'd12, 1'b0, 11'd3, 1'b0, 11'd3);
    mem[1] = ins(2'd1, 4'd1,  1'b0, 11'd9, 1'b0, 11'd0);
    mem[2] = ins(2'd2, 4'd1,  1'b0, 11'd1, 1'b0, 11'd0);
    do_reset();
    tick(2);
    check("teq_flag", 32'(flag_q), 1);
    check("teq_vld",  32'(flag_vld), 1);
    tick(2);
    check("cond_pos_acc", 32'(acc_q), 9);
    tick(2);
    check("cond_neg_acc", 32'(acc_q), 9);
    check("cond_neg_pc",  32'(prog_addr), 3);

    // +MOV 4 straight after reset: flag not valid
    clear_mem();
    mem[0] = ins(2'd1, 4'd1, 1'b0, 11'd4, 1'b0, 11'd0);
    do_reset();
    tick(2);
    check("novld_acc", 32'(acc_q), 0);
    check("novld_pc",  32'(prog_addr), 1);

    // Signed tests with in_p0 = -5
    clear_mem();
    in_p0  = 11'h7FB;
    mem[0] = ins(2'd0, 4'd1,  1'b1, 11'd2, 1'b0, 11'd0);
    mem[1] = ins(2'd0, 4'd13, 1'b1, 11'd0, 1'b0, 11'd2);
    mem[2] = ins(2'd0, 4'd14, 1'b1, 11'd0, 1'b0, 11'd2);
    do_reset();
    tick(2);
    check("mov_port_acc", 32'(acc_q), 32'h7FB);
    tick(2);
    check("tgt_flag", 32'(flag_q), 0);
    check("tgt_vld",  32'(flag_vld), 1);
    tick(2);
    check("tlt_flag", 32'(flag_q), 1);

    // JMP targets; word 0 is rewritten while the DUT is in FETCH
    clear_mem();
    in_p0  = 11'd7;
    mem[0] = ins(2'd0, 4'd3, 1'b0, 11'd20, 1'b0, 11'd0);
    do_reset();
    tick(2);
    check("jmp20_pc", 32'(prog_addr), 0);
    mem[0] = ins(2'd0, 4'd3, 1'b0, 11'h7FF, 1'b0, 11'd0);
    tick(2);
    check("jmpneg_pc", 32'(prog_addr), 0);
    mem[0] = ins(2'd0, 4'd3, 1'b1, 11'd2, 1'b0, 11'd0);
    tick(2);
    check("jmp_port_pc", 32'(prog_addr), 7);
    mem[7] = ins(2'd0, 4'd3, 1'b0, 11'd13, 1'b0, 11'd0);
    tick(2);
    check("jmp13_pc", 32'(prog_addr), 13);
    tick(2);
    check("wrap_pc", 32'(prog_addr), 0);

    // SLP 3 then MOV 33: acc changes at the end of cycle 7 after reset release
    clear_mem();
    mem[0] = ins(2'd0, 4'd4, 1'b0, 11'd3, 1'b0, 11'd0);
    mem[1] = ins(2'd0, 4'd1, 1'b0, 11'd33, 1'b0, 11'd0);
    do_reset();
    tick(2);
    check("slp3_pc", 32'(prog_addr), 1);
    tick(4);
    check("slp3_acc_before", 32'(acc_q), 0);
    check("slp3_pc_hold",    32'(prog_addr), 1);
    tick(1);
    check("slp3_acc_after", 32'(acc_q), 33);
    check("slp3_pc_after",  32'(prog_addr), 2);

    // SLP 0 and SLP -2 do not sleep
    clear_mem();
    mem[0] = ins(2'd0, 4'd4, 1'b0, 11'd0, 1'b0, 11'd0);
    mem[1] = ins(2'd0, 4'd1, 1'b0, 11'd21, 1'b0, 11'd0);
    mem[2] = ins(2'd0, 4'd4, 1'b0, 11'h7FE, 1'b0, 11'd0);
    mem[3] = ins(2'd0, 4'd2, 1'b0, 11'd22, 1'b0, 11'd0);
    do_reset();
    tick(4);
    check("slp0_acc", 32'(acc_q), 21);
    tick(4);
    check("slpneg_dat", 32'(dat_q), 22);
    check("slpneg_pc",  32'(prog_addr), 4);

    // SWP with acc=2, dat=8, then SUB 3
    clear_mem();
    mem[0] = ins(2'd0, 4'd1, 1'b0, 11'd2, 1'b0, 11'd0);
    mem[1] = ins(2'd0, 4'd2, 1'b0, 11'd8, 1'b0, 11'd0);
    mem[2] = ins(2'd0, 4'd9, 1'b0, 11'd0, 1'b0, 11'd0);
    mem[3] = ins(2'd0, 4'd6, 1'b0, 11'd3, 1'b0, 11'd0);
    do_reset();
    tick(6);
    check("swp_acc", 32'(acc_q), 8);
    check("swp_dat", 32'(dat_q), 2);
    tick(2);
    check("sub_acc", 32'(acc_q), 5);

    // Reset in the 2nd SLEEP cycle of SLP 5
    clear_mem();
    mem[0] = ins(2'd0, 4'd12, 1'b0, 11'd1, 1'b0, 11'd1);
    mem[1] = ins(2'd0, 4'd1,  1'b0, 11'd7, 1'b0, 11'd0);
    mem[2] = ins(2'd0, 4'd4,  1'b0, 11'd5, 1'b0, 11'd0);
    do_reset();
    tick(6);
    check("pre_rst_acc", 32'(acc_q), 7);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("slp_rst_acc",       32'(acc_q), 0);
    check("slp_rst_dat",       32'(dat_q), 0);
    check("slp_rst_flag",      32'(flag_q), 0);
    check("slp_rst_vld",       32'(flag_vld), 0);
    check("slp_rst_prog_addr", 32'(prog_addr), 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_alu_inst", 32'(alu_inst), 0);
    tick(1);
    check("post_rst_teq_vld", 32'(flag_vld), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
